// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg
// Shared definitions for the serial parity receiver: the frame FSM state
// encoding, the error-counter width/limit and the XOR stage function that
// mirrors the upstream NOR-built XOR cell.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int                  ERRCNT_W   = 8;
    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = 8'hFF;

    // Two-input XOR built from four NORs (the classic cell), with a final
    // NOR used as an inverter to turn the XNOR into XOR.
    function automatic logic xor_stage(input logic a, input logic b);
        logic n1, n2, n3, xnor_v;
        n1     = ~(a | b);
        n2     = ~(a | n1);
        n3     = ~(b | n1);
        xnor_v = ~(n2 | n3);
        return ~(xnor_v | xnor_v);
    endfunction

endpackage

// File: rtl/serial_parity_rx_parity_accum.sv
// parity_accum
// One-bit running XOR accumulator. clr_i has priority over en_i and zeroes
// the accumulator; en_i folds bit_i into it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear
//   en_i       : accumulate enable
//   bit_i      : bit to fold in
//   par_o      : current accumulated parity
module parity_accum
    import serial_parity_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    input  logic bit_i,
    output logic par_o
);

    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (clr_i) begin
            par_d = 1'b0;
        end else if (en_i) begin
            par_d = xor_stage(par_q, bit_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_o = par_q;

endmodule

// File: rtl/serial_parity_rx.sv
// serial_parity_rx
// Serial frame receiver: DATA_W data bits LSB-first followed by one parity
// bit. The completed word is presented on data_out with a one-cycle
// data_valid strobe and a parity_err flag that stay held until the next
// frame completes. A start pulse in any state (re)opens a frame.
// Optional build: define SERIAL_PARITY_RX_ERRCNT_EN to build a saturating
// 8-bit parity-error counter on err_cnt; otherwise err_cnt is tied to zero.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : frame start pulse (no bit accepted on this cycle)
//   din         : serial data / parity bit
//   din_valid   : din qualifier
//   data_out    : last received word
//   data_valid  : one-cycle frame-complete strobe
//   parity_err  : parity mismatch flag for data_out
//   busy        : frame in progress (DATA or PAR)
//   err_cnt     : saturating count of frames with parity errors
module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                din,
    input  logic                din_valid,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_valid,
    output logic                parity_err,
    output logic                busy,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                perr_q, perr_d;
    logic                par_clr, par_en, par_run;

    parity_accum u_parity_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (par_clr),
        .en_i  (par_en),
        .bit_i (din),
        .par_o (par_run)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        perr_d  = perr_q;
        par_clr = 1'b0;
        par_en  = 1'b0;

        // start wins over everything, including a concurrent din_valid, and
        // aborts any frame in flight. In DONE it chains the next frame with
        // no idle cycle; the strobe for the finished frame still fires.
        if (start) begin
            state_d = DATA;
            cnt_d   = '0;
            shreg_d = '0;
            par_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: ;
                DATA: begin
                    if (din_valid) begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (cnt_q == CNT_W'(i)) shreg_d[i] = din;
                        end
                        par_en = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = PAR;
                    end
                end
                PAR: begin
                    if (din_valid) begin
                        perr_d  = xor_stage(xor_stage(par_run, din), PARITY_ODD);
                        data_d  = shreg_q;
                        state_d = DONE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
        end
    end

    assign data_out   = data_q;
    assign parity_err = perr_q;
    assign data_valid = (state_q == DONE);
    assign busy       = (state_q == DATA) || (state_q == PAR);

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

    // perr_q is loaded on entry to DONE, so it already describes this frame.
    always_comb begin
        errcnt_d = errcnt_q;
        if ((state_q == DONE) && perr_q && (errcnt_q != ERRCNT_MAX)) begin
            errcnt_d = errcnt_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign err_cnt = errcnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
module tb_serial_parity_rx;
    import serial_parity_pkg::*;

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, din = 1'b0, din_valid = 1'b0;
    logic [7:0] dout_e, dout_o, ecnt_e, ecnt_o;
    logic dv_e, dv_o, pe_e, pe_o, busy_e, busy_o;

    always #5 clk = ~clk;

    // Even-parity and odd-parity receivers share one stimulus stream.
    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e), .busy(busy_e), .err_cnt(ecnt_e));
    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_o (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o), .busy(busy_o), .err_cnt(ecnt_o));

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic [7:0] ecnt;
    } exp_t;

    exp_t q_e[$], q_o[$];
    int errors = 0, checks = 0;
    int unsigned cnt_e = 0, cnt_o = 0;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       perr_even;
        logic       gaps;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: both DUTs are checked whenever they strobe data_valid.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (rst_n) begin
            if (dv_e) begin
                if (q_e.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL even_unexpected_valid: got data %0h expected no strobe", dout_e);
                end else begin
                    x = q_e.pop_front();
                    check("even_data", dout_e, x.data);
                    check("even_perr", {7'd0, pe_e}, {7'd0, x.perr});
                    check("even_errcnt", ecnt_e, x.ecnt);
                end
            end
            if (dv_o) begin
                if (q_o.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL odd_unexpected_valid: got data %0h expected no strobe", dout_o);
                end else begin
                    x = q_o.pop_front();
                    check("odd_data", dout_o, x.data);
                    check("odd_perr", {7'd0, pe_o}, {7'd0, x.perr});
                    check("odd_errcnt", ecnt_o, x.ecnt);
                end
            end
        end
    end

    task automatic cyc(input logic s, input logic v, input logic d);
        start = s; din_valid = v; din = d;
        @(posedge clk); #1;
        start = 1'b0; din_valid = 1'b0;
    endtask

    // err_cnt seen during DONE is the count before this frame's increment.
    task automatic expect_frame(input logic [7:0] d, input logic perr_even);
        exp_t x;
        x.data = d; x.perr = perr_even; x.ecnt = ERR_EN ? 8'(cnt_e) : 8'h00;
        q_e.push_back(x);
        if (perr_even && cnt_e < 255) cnt_e++;
        x.perr = ~perr_even; x.ecnt = ERR_EN ? 8'(cnt_o) : 8'h00;
        q_o.push_back(x);
        if (!perr_even && cnt_o < 255) cnt_o++;
    endtask

    // Start cycle also carries din_valid=1 to show start discards the bit.
    task automatic send_frame(input vec_t v);
        expect_frame(v.data, v.perr_even);
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (v.gaps) cyc(1'b0, 1'b0, ~v.data[i]);
            cyc(1'b0, 1'b1, v.data[i]);
        end
        cyc(1'b0, 1'b1, v.pbit);
    endtask

    // data, parity bit, expected even-parity error, din_valid gaps
    vec_t vecs[6] = '{
        '{8'hA5, 1'b0, 1'b0, 1'b0},
        '{8'hA5, 1'b1, 1'b1, 1'b0},
        '{8'h00, 1'b1, 1'b1, 1'b0},
        '{8'h00, 1'b0, 1'b0, 1'b0},
        '{8'h3C, 1'b0, 1'b0, 1'b1},
        '{8'hFF, 1'b0, 1'b0, 1'b0}
    };

    initial begin
        logic [7:0] part;
        vec_t v;
        #2;
        check("reset_data", dout_e, 8'h00);
        check("reset_valid", {7'd0, dv_e}, 8'h00);
        check("reset_busy", {7'd0, busy_e}, 8'h00);
        check("reset_errcnt", ecnt_e, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;

        // din_valid in IDLE must be ignored
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check("idle_busy", {7'd0, busy_e}, 8'h00);

        for (int i = 0; i < 4; i++) begin
            send_frame(vecs[i]);
            cyc(1'b0, 1'b0, 1'b0);
        end
        // 0x3C with gaps, then 0xFF started in the DONE cycle
        send_frame(vecs[4]);
        send_frame(vecs[5]);
        cyc(1'b0, 1'b0, 1'b0);

        // abort 0x12 after 4 bits, then full 0x81
        part = 8'h12;
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, part[i]);
        check("abort_busy", {7'd0, busy_e}, 8'h01);
        v = '{8'h81, 1'b0, 1'b0, 1'b0};
        send_frame(v);
        cyc(1'b0, 1'b0, 1'b0);

        // reset while in PAR
        part = 8'h5A;
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, part[i]);
        check("par_busy", {7'd0, busy_e}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("rst_data_e", dout_e, 8'h00);
        check("rst_data_o", dout_o, 8'h00);
        check("rst_perr_o", {7'd0, pe_o}, 8'h00);
        check("rst_valid", {7'd0, dv_e}, 8'h00);
        check("rst_busy", {7'd0, busy_e}, 8'h00);
        check("rst_errcnt_e", ecnt_e, 8'h00);
        check("rst_errcnt_o", ecnt_o, 8'h00);
        cnt_e = 0; cnt_o = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        v = '{8'h01, 1'b1, 1'b0, 1'b0};
        send_frame(v);
        cyc(1'b0, 1'b0, 1'b0);

`ifdef SERIAL_PARITY_RX_ERRCNT_EN
        // drive the even counter past 255 and confirm it holds
        v = '{8'h00, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 257; i++) send_frame(v);
        v = '{8'hA5, 1'b0, 1'b0, 1'b0};
        send_frame(v);
        cyc(1'b0, 1'b0, 1'b0);
        check("sat_errcnt", ecnt_e, 8'hFF);
`endif

        for (int i = 0; i < 20 && (q_e.size() != 0 || q_o.size() != 0); i++) cyc(1'b0, 1'b0, 1'b0);
        check("pending_even", 8'(q_e.size()), 8'h00);
        check("pending_odd", 8'(q_o.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
